// File: rtl/conv_pool_pkg.sv
// Shared definitions for the conv_pool sequencer: pixel/window geometry, FSM states and
// bit-offset helpers for the packed window and kernel buses.
package conv_pool_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned WIN       = 4;
  localparam int unsigned KERN_TAPS = 9;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} cp_state_e;

  // LSB of pixel (r,c) inside a packed 4x4 window.
  function automatic int unsigned win_lsb(input int unsigned r, input int unsigned c);
    return PIX_W * (WIN * r + c);
  endfunction

  // LSB of tap k inside the packed 3x3 kernel.
  function automatic int unsigned kern_lsb(input int unsigned k);
    return PIX_W * k;
  endfunction

endpackage

// File: rtl/conv_pool_win_mux.sv
// Combinational extraction of a 4x4 window from the flattened frame at a given origin.
module conv_pool_win_mux
  import conv_pool_pkg::*;
#(
  parameter int unsigned IMG_DIM = 8,
  localparam int unsigned OW = $clog2(IMG_DIM)
) (
  input  logic [IMG_DIM*IMG_DIM*PIX_W-1:0] frame,
  input  logic [OW-1:0]                    org_row,
  input  logic [OW-1:0]                    org_col,
  output logic [WIN*WIN*PIX_W-1:0]         window
);

  always_comb begin
    window = '0;
    for (int unsigned r = 0; r < WIN; r++) begin
      for (int unsigned c = 0; c < WIN; c++) begin
        window[win_lsb(r, c) +: PIX_W] =
          frame[((32'(org_row) + r) * IMG_DIM + 32'(org_col) + c) * PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/conv_pool_seq.sv
// Frame sequencer for conv_pool: buffers a frame, issues one 4x4 window per cycle and tags
// the returned results with grid coordinates. CONV_POOL_SEQ_CYCCNT_EN adds perf_cycles.
module conv_pool_seq
  import conv_pool_pkg::*;
#(
  parameter int unsigned IMG_DIM    = 8,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned CP_LATENCY = 3,
  localparam int unsigned G  = (IMG_DIM - 4) / STRIDE + 1,
  localparam int unsigned AW = $clog2(IMG_DIM * IMG_DIM),
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_we,
  input  logic [AW-1:0]              pix_addr,
  input  logic [PIX_W-1:0]           pix_wdata,
  input  logic [KERN_TAPS*PIX_W-1:0] kern_in,
  input  logic [1:0]                 shift_in,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [WIN*WIN*PIX_W-1:0]   cp_image_4x4,
  output logic [KERN_TAPS*PIX_W-1:0] cp_conv_kernel,
  output logic [1:0]                 cp_shift,
  input  logic [PIX_W-1:0]           cp_y,
  output logic                       out_valid,
  output logic [GW-1:0]              out_row,
  output logic [GW-1:0]              out_col,
`ifdef CONV_POOL_SEQ_CYCCNT_EN
  output logic [15:0]                perf_cycles,
`endif
  output logic [PIX_W-1:0]           out_y
);

  localparam int unsigned OW = $clog2(IMG_DIM);
  localparam int unsigned DW = $clog2(CP_LATENCY + 1);
  localparam logic [GW-1:0] GLAST = GW'(G - 1);

  logic [IMG_DIM*IMG_DIM*PIX_W-1:0] frame_q;
  cp_state_e                        state_q;
  logic [GW-1:0]                    wr_q, wc_q;
  logic [DW-1:0]                    drain_q;
  logic                             busy_q, done_q;
  logic [WIN*WIN*PIX_W-1:0]         image_q;
  logic [KERN_TAPS*PIX_W-1:0]       kern_q;
  logic [1:0]                       shift_q;
  logic                             tag_v_q [CP_LATENCY];
  logic [GW-1:0]                    tag_r_q [CP_LATENCY];
  logic [GW-1:0]                    tag_c_q [CP_LATENCY];
  logic                             out_valid_q;
  logic [GW-1:0]                    out_row_q, out_col_q;
  logic [OW-1:0]                    org_row, org_col;
  logic [WIN*WIN*PIX_W-1:0]         win_sel;

  assign org_row = OW'(32'(wr_q) * STRIDE);
  assign org_col = OW'(32'(wc_q) * STRIDE);

  conv_pool_win_mux #(
    .IMG_DIM(IMG_DIM)
  ) u_win_mux (
    .frame  (frame_q),
    .org_row(org_row),
    .org_col(org_col),
    .window (win_sel)
  );

  // Frame buffer is deliberately not reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && pix_we && 32'(pix_addr) < IMG_DIM * IMG_DIM) begin
      frame_q[32'(pix_addr) * PIX_W +: PIX_W] <= pix_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      wc_q    <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      image_q <= '0;
      kern_q  <= '0;
      shift_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            kern_q  <= kern_in;
            shift_q <= shift_in;
            wr_q    <= '0;
            wc_q    <= '0;
            drain_q <= '0;
          end
        end
        ISSUE: begin
          image_q <= win_sel;
          if (wc_q == GLAST) begin
            wc_q <= '0;
            if (wr_q == GLAST) begin
              state_q <= DRAIN;
            end else begin
              wr_q <= wr_q + 1'b1;
            end
          end else begin
            wc_q <= wc_q + 1'b1;
          end
        end
        DRAIN: begin
          // One extra cycle beyond the tag depth covers the registered out_valid stage.
          if (drain_q == DW'(CP_LATENCY)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CP_LATENCY; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_r_q[i] <= '0;
        tag_c_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      tag_v_q[0] <= (state_q == ISSUE);
      tag_r_q[0] <= (state_q == ISSUE) ? wr_q : '0;
      tag_c_q[0] <= (state_q == ISSUE) ? wc_q : '0;
      for (int i = 1; i < CP_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_r_q[i] <= tag_r_q[i-1];
        tag_c_q[i] <= tag_c_q[i-1];
      end
      out_valid_q <= tag_v_q[CP_LATENCY-1];
      out_row_q   <= tag_r_q[CP_LATENCY-1];
      out_col_q   <= tag_c_q[CP_LATENCY-1];
    end
  end

`ifdef CONV_POOL_SEQ_CYCCNT_EN
  logic [15:0] perf_q;

  // The accepting start cycle counts as the first cycle of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_q <= 16'd1;
    end else if (busy_q && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign cp_image_4x4   = image_q;
  assign cp_conv_kernel = kern_q;
  assign cp_shift       = shift_q;
  assign out_valid      = out_valid_q;
  assign out_row        = out_row_q;
  assign out_col        = out_col_q;
  assign out_y          = out_valid_q ? cp_y : '0;

endmodule

// File: tb/tb_conv_pool_seq.sv
// Self-checking bench for conv_pool_seq: an 8x8/stride-2 instance and a 4x4/stride-1 instance,
// each fed by a small delayed-function stand-in for conv_pool.
module tb_conv_pool_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         pix_we;
  logic [5:0]   pix_addr;
  logic [7:0]   pix_wdata;
  logic [71:0]  kern_in;
  logic [1:0]   shift_in;
  logic         start;
  logic         busy, done, out_valid;
  logic [127:0] cp_image;
  logic [71:0]  cp_kern;
  logic [1:0]   cp_shift;
  logic [7:0]   cp_y, out_y;
  logic [1:0]   out_row, out_col;

  logic         pix_we4;
  logic [3:0]   pix_addr4;
  logic [7:0]   pix_wdata4;
  logic         start4;
  logic         busy4, done4, out_valid4;
  logic [127:0] cp_image4;
  logic [71:0]  cp_kern4;
  logic [1:0]   cp_shift4;
  logic [7:0]   cp_y4, out_y4;
  logic [0:0]   out_row4, out_col4;

`ifdef CONV_POOL_SEQ_CYCCNT_EN
  logic [15:0] perf_cycles, perf_cycles4;
`endif

  conv_pool_seq #(.IMG_DIM(8), .STRIDE(2), .CP_LATENCY(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .pix_we(pix_we), .pix_addr(pix_addr), .pix_wdata(pix_wdata),
    .kern_in(kern_in), .shift_in(shift_in), .start(start), .busy(busy), .done(done),
    .cp_image_4x4(cp_image), .cp_conv_kernel(cp_kern), .cp_shift(cp_shift), .cp_y(cp_y),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
`ifdef CONV_POOL_SEQ_CYCCNT_EN
    .perf_cycles(perf_cycles),
`endif
    .out_y(out_y)
  );

  conv_pool_seq #(.IMG_DIM(4), .STRIDE(1), .CP_LATENCY(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pix_we(pix_we4), .pix_addr(pix_addr4), .pix_wdata(pix_wdata4),
    .kern_in(kern_in), .shift_in(shift_in), .start(start4), .busy(busy4), .done(done4),
    .cp_image_4x4(cp_image4), .cp_conv_kernel(cp_kern4), .cp_shift(cp_shift4), .cp_y(cp_y4),
    .out_valid(out_valid4), .out_row(out_row4), .out_col(out_col4),
`ifdef CONV_POOL_SEQ_CYCCNT_EN
    .perf_cycles(perf_cycles4),
`endif
    .out_y(out_y4)
  );

  // Stand-in for conv_pool: y = p(0,0) ^ p(1,1) ^ p(3,3), three edges after the window.
  function automatic logic [7:0] cp_func(input logic [127:0] w);
    return w[7:0] ^ w[47:40] ^ w[127:120];
  endfunction

  logic [7:0] pipe8 [3];
  logic [7:0] pipe4 [3];
  always @(posedge clk) begin
    pipe8[0] <= cp_func(cp_image);
    pipe8[1] <= pipe8[0];
    pipe8[2] <= pipe8[1];
    pipe4[0] <= cp_func(cp_image4);
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
  end
  assign cp_y  = pipe8[2];
  assign cp_y4 = pipe4[2];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic check_wide(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic [7:0] mem8 [64];
  logic [7:0] mem4 [16];

  typedef struct { int row; int col; int y; } exp_t;
  exp_t q8[$];
  exp_t q4[$];

  function automatic int exp_y8(input int wr, input int wc);
    int r0, c0;
    r0 = 2 * wr;
    c0 = 2 * wc;
    return int'(mem8[r0*8+c0] ^ mem8[(r0+1)*8+c0+1] ^ mem8[(r0+3)*8+c0+3]);
  endfunction

  int ov8_cnt = 0, done8_cnt = 0, ov4_cnt = 0, done4_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      ov8_cnt++;
      if (q8.size() == 0) begin
        check("sb8_unexpected_valid", 1, 0);
      end else begin
        e = q8.pop_front();
        check("sb8_row", int'(out_row), e.row);
        check("sb8_col", int'(out_col), e.col);
        check("sb8_y", int'(out_y), e.y);
      end
    end
    if (done) done8_cnt++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid4) begin
      ov4_cnt++;
      if (q4.size() == 0) begin
        check("sb4_unexpected_valid", 1, 0);
      end else begin
        e = q4.pop_front();
        check("sb4_row", int'(out_row4), e.row);
        check("sb4_col", int'(out_col4), e.col);
        check("sb4_y", int'(out_y4), e.y);
      end
    end
    if (done4) done4_cnt++;
  end

  localparam int NREC = 17;
  int rec_busy [NREC];
  int rec_done [NREC];
  int rec_ov   [NREC];
  int rec_y    [NREC];
  int rec_p0   [NREC];
  int rec_kok  [NREC];
`ifdef CONV_POOL_SEQ_CYCCNT_EN
  int rec_perf [NREC];
`endif

  typedef struct { int k; int busy; int done; int ov; int p0; } vec_t;

  task automatic load8();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pix_we    = 1'b1;
      pix_addr  = 6'(i);
      pix_wdata = 8'(i);
      mem8[i]   = 8'(i);
    end
    @(negedge clk);
    pix_we = 1'b0;
  endtask

  // Runs one 8x8 frame; k indexes the sample taken after start edge k.
  task automatic run8(input int mid_start_k, input int mid_we_k,
                      input logic [71:0] ka, input logic [71:0] kb);
    exp_t e;
    @(negedge clk);
    kern_in  = ka;
    shift_in = 2'b10;
    start    = 1'b1;
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        e.row = wr;
        e.col = wc;
        e.y   = exp_y8(wr, wc);
        q8.push_back(e);
      end
    end
    @(posedge clk);
    for (int k = 0; k < NREC; k++) begin
      @(negedge clk);
      kern_in   = kb;
      start     = (k == mid_start_k);
      pix_we    = (k == mid_we_k);
      pix_addr  = 6'd0;
      pix_wdata = 8'hFF;
      rec_busy[k] = int'(busy);
      rec_done[k] = int'(done);
      rec_ov[k]   = int'(out_valid);
      rec_y[k]    = int'(out_y);
      rec_p0[k]   = int'(cp_image[7:0]);
      rec_kok[k]  = int'(cp_kern == ka && cp_shift == 2'b10);
`ifdef CONV_POOL_SEQ_CYCCNT_EN
      rec_perf[k] = int'(perf_cycles);
`endif
    end
    start  = 1'b0;
    pix_we = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab8 [10];
    vec_t tab4 [11];
    logic [71:0] ka, kb;
    int d0, o0, kall;
    exp_t e;

    tab8[0] = '{0,  1, 0, 0, -1};
    tab8[1] = '{1,  1, 0, 0, 8'h00};
    tab8[2] = '{3,  1, 0, 0, -1};
    tab8[3] = '{4,  1, 0, 1, -1};
    tab8[4] = '{6,  1, 0, 1, 8'h14};
    tab8[5] = '{9,  1, 0, 1, 8'h24};
    tab8[6] = '{12, 1, 0, 1, -1};
    tab8[7] = '{13, 1, 1, 0, -1};
    tab8[8] = '{14, 0, 0, 0, -1};
    tab8[9] = '{15, 0, 0, 0, 8'h24};

    tab4[0]  = '{3,  1, 0, 0, -1};
    tab4[1]  = '{4,  1, 0, 1, -1};
    tab4[2]  = '{5,  1, 1, 0, -1};
    tab4[3]  = '{6,  0, 0, 0, -1};
    tab4[4]  = '{7,  1, 0, 0, -1};
    tab4[5]  = '{10, 1, 0, 0, -1};
    tab4[6]  = '{11, 1, 0, 1, -1};
    tab4[7]  = '{12, 1, 1, 0, -1};
    tab4[8]  = '{13, 0, 0, 0, -1};
    tab4[9]  = '{1,  1, 0, 0, -1};
    tab4[10] = '{0,  1, 0, 0, -1};

    rst_n = 1'b0; pix_we = 1'b0; pix_addr = '0; pix_wdata = '0; kern_in = '0;
    shift_in = '0; start = 1'b0; pix_we4 = 1'b0; pix_addr4 = '0; pix_wdata4 = '0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_rowcol_y", int'({out_row, out_col, out_y}), 0);
    check_wide("rst_image", cp_image, '0);
    check_wide("rst_kern_shift", {cp_kern, cp_shift}, '0);

    // Nominal 8x8 frame, kernel changed the cycle after start.
    load8();
    ka = {$urandom, $urandom, $urandom};
    kb = ~ka;
    run8(-1, -1, ka, kb);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("t8_busy_k%0d", tab8[j].k), rec_busy[tab8[j].k], tab8[j].busy);
      check($sformatf("t8_done_k%0d", tab8[j].k), rec_done[tab8[j].k], tab8[j].done);
      check($sformatf("t8_valid_k%0d", tab8[j].k), rec_ov[tab8[j].k], tab8[j].ov);
      if (tab8[j].ov == 0) check($sformatf("t8_ylow_k%0d", tab8[j].k), rec_y[tab8[j].k], 0);
      if (tab8[j].p0 >= 0) check($sformatf("t8_p0_k%0d", tab8[j].k), rec_p0[tab8[j].k],
                                 tab8[j].p0);
    end
    kall = 1;
    for (int k = 0; k < 14; k++) kall = kall & rec_kok[k];
    check("t8_kernel_held", kall, 1);
    check("t8_valid_count", ov8_cnt, 9);
    check("t8_done_count", done8_cnt, 1);
    check("t8_queue_empty", q8.size(), 0);
`ifdef CONV_POOL_SEQ_CYCCNT_EN
    check("perf_after_frame", rec_perf[15], 15);
    check("perf_holds", rec_perf[16], 15);
`endif

    // Start and pixel write during the frame are both ignored.
    run8(3, 5, kb, ka);
`ifdef CONV_POOL_SEQ_CYCCNT_EN
    check("perf_cleared_on_start", rec_perf[0], 1);
`endif
    check("mid_p0_unchanged", rec_p0[1], 0);
    check("mid_busy_k13", rec_busy[13], 1);
    check("mid_busy_k14", rec_busy[14], 0);
    check("mid_valid_k12", rec_ov[12], 1);
    check("mid_valid_k13", rec_ov[13], 0);
    check("mid_valid_count", ov8_cnt, 18);
    check("mid_done_count", done8_cnt, 2);

    @(negedge clk);
    pix_we = 1'b1; pix_addr = 6'd0; pix_wdata = 8'hFF; mem8[0] = 8'hFF;
    @(negedge clk);
    pix_we = 1'b0;
    run8(-1, -1, ka, ka);
    check("next_p0_ff", rec_p0[1], 8'hFF);
    check("next_valid_count", ov8_cnt, 27);

    // Reset during the fifth ISSUE cycle aborts the frame.
    @(negedge clk);
    start = 1'b1;
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        e.row = wr; e.col = wc; e.y = exp_y8(wr, wc);
        q8.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_valid", int'(out_valid), 0);
    check("abort_rowcol_y", int'({out_row, out_col, out_y}), 0);
    check_wide("abort_image", cp_image, '0);
    check_wide("abort_kern_shift", {cp_kern, cp_shift}, '0);
    q8.delete();
    d0 = done8_cnt;
    o0 = ov8_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done8_cnt, d0);
    check("abort_no_valid", ov8_cnt, o0);
    run8(-1, -1, ka, ka);
    check("after_abort_valid_count", ov8_cnt, o0 + 9);
    check("after_abort_done_count", done8_cnt, d0 + 1);
    check("after_abort_queue_empty", q8.size(), 0);

    // 4x4, stride 1: single window, start held through DONE into the first IDLE cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pix_we4 = 1'b1; pix_addr4 = 4'(i); pix_wdata4 = 8'(8'hA0 + i); mem4[i] = 8'(8'hA0 + i);
    end
    @(negedge clk);
    pix_we4 = 1'b0;
    start4  = 1'b1;
    e.row = 0; e.col = 0; e.y = int'(mem4[0] ^ mem4[5] ^ mem4[15]);
    q4.push_back(e);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start4 = (k == 5 || k == 6);
      if (k == 6) q4.push_back(e);
      rec_busy[k] = int'(busy4);
      rec_done[k] = int'(done4);
      rec_ov[k]   = int'(out_valid4);
    end
    start4 = 1'b0;
    for (int j = 0; j < 11; j++) begin
      check($sformatf("t4_busy_k%0d", tab4[j].k), rec_busy[tab4[j].k], tab4[j].busy);
      check($sformatf("t4_done_k%0d", tab4[j].k), rec_done[tab4[j].k], tab4[j].done);
      check($sformatf("t4_valid_k%0d", tab4[j].k), rec_ov[tab4[j].k], tab4[j].ov);
    end
    repeat (4) @(negedge clk);
    check("t4_valid_count", ov4_cnt, 2);
    check("t4_done_count", done4_cnt, 2);
    check("t4_queue_empty", q4.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/conv_pool_seq.md
# conv_pool_seq

Frame-level sequencer for the `conv_pool` datapath. It holds an IMG_DIM×IMG_DIM 8-bit frame buffer and latches the kernel and shift at start. It tiles the frame into 4×4 windows and issues one window per cycle to `conv_pool`. It tracks the pipeline latency and tags each returned `y` with its output-grid coordinates. It sits between the host/DMA load interface and a `conv_pool` instance, and owns all sequencing of that instance.

## Interface
Parameters:
- IMG_DIM, 8, frame edge in pixels; IMG_DIM ≥ 4.
- STRIDE, 2, window step in pixels; (IMG_DIM−4) % STRIDE == 0.
- CP_LATENCY, 3, clock edges from a window on `cp_image_4x4` to its `cp_y`.

Derived values:
- G = (IMG_DIM−4)/STRIDE + 1, the output-grid edge.
- N = G², the number of windows per frame.
- AW = clog2(IMG_DIM²).
- GW = max(1, clog2(G)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_we  in  1  pixel write strobe.
- pix_addr  in  AW  pixel address, row*IMG_DIM+col.
- pix_wdata  in  8  unsigned pixel.
- kern_in  in  72  9 signed 8-bit taps; tap k = 3r+c at [8k+7:8k].
- shift_in  in  2  post-scale shift.
- start  in  1  frame start request.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.
- cp_image_4x4  out  128  window; pixel (r,c) at [8(4r+c)+7 : 8(4r+c)].
- cp_conv_kernel  out  72  latched kernel.
- cp_shift  out  2  latched shift.
- cp_y  in  8  `conv_pool` result.
- out_valid  out  1  out_y is valid this cycle.
- out_row, out_col  out  GW each  grid coordinates of out_y.
- out_y  out  8  cp_y when out_valid, else 0.

## Operation
- The FSM states are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - pix_we writes the frame buffer.
  - start=1 latches kern_in→cp_conv_kernel and shift_in→cp_shift, clears the window counter, and moves to ISSUE.
- ISSUE:
  - Each cycle registers window (wr,wc) onto cp_image_4x4 in raster order: wc fastest, origin pixel (wr*STRIDE, wc*STRIDE).
  - It pushes a valid bit and (wr,wc) into a CP_LATENCY-deep tag shift register.
  - After window N−1 it moves to DRAIN.
- DRAIN: counts CP_LATENCY cycles with no new valid pushed, then moves to DONE.
- DONE: done=1 for one cycle, then returns to IDLE.
- The tag shift register output drives out_valid, out_row and out_col. Exactly N out_valid pulses occur per frame, in raster order.
- busy=1 in ISSUE, DRAIN and DONE.
- While busy:
  - start is ignored.
  - pix_we is ignored; the frame buffer is frozen.
  - kern_in and shift_in are ignored.
- start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- The frame buffer is not reset; the host reloads it.

## Timing
- Reset values:
  - FSM goes to IDLE.
  - busy, done and out_valid are 0.
  - cp_image_4x4, cp_conv_kernel and cp_shift are 0.
  - out_row, out_col and out_y are 0.
  - The tag register is cleared.
- A reset asserted mid-frame aborts the frame. No further out_valid is produced and no done pulse is produced.
- Let the start edge be edge 0:
  - busy rises after edge 0.
  - Window i is on cp_image_4x4 after edge 1+i.
  - The first out_valid comes after edge 1+CP_LATENCY.
  - The last out_valid comes after edge N+CP_LATENCY.
  - done is high after edge N+CP_LATENCY+1.
  - busy falls after edge N+CP_LATENCY+2.
- Frame period is N+CP_LATENCY+3 cycles, start to start.
- cp_image_4x4 holds its last window outside ISSUE.
- A pixel written at edge k is visible to a frame started at edge k+1.

## Configuration
- CONV_POOL_SEQ_CYCCNT_EN defined:
  - Adds output perf_cycles[15:0], reset 0.
  - Cleared on accepted start.
  - Increments every cycle busy=1.
  - Saturates at 16'hFFFF.
  - Holds its value in IDLE.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `conv_pool_pkg`:
  - PIX_W=8, WIN=4, KERN_TAPS=9.
  - State enum {IDLE, ISSUE, DRAIN, DONE}.
  - Window and kernel packing index functions.
- Sub-module `conv_pool_win_mux`: combinational extraction of the 4×4 window from the flattened frame at a given origin.

## Test plan
- IMG_DIM=8, STRIDE=2, pixel(r,c)=8r+c, start:
  - 9 out_valid pulses with (row,col) = (0,0)…(2,2).
  - Window (1,2) has pixel(0,0)=8'h14.
  - done comes 13 cycles after start.
- Start during ISSUE, and pix_we writing 8'hFF to addr 0 mid-frame:
  - Neither affects the current frame.
  - The next frame sees 8'hFF at window (0,0) pixel 0.
- rst_n low at the 5th ISSUE cycle:
  - All outputs read 0 immediately.
  - No done pulse.
  - A new start yields a full 9-result frame.
- kern_in changed on the cycle after start:
  - cp_conv_kernel keeps the start-cycle value for the whole frame.
- IMG_DIM=4, STRIDE=1:
  - N=1, 1 out_valid with (0,0).
  - done 5 cycles after start.
  - Back-to-back start in the first IDLE cycle is accepted.
- With CONV_POOL_SEQ_CYCCNT_EN, 8×8/stride 2:
  - perf_cycles=15 after the frame; it holds, then clears on the next start.
